// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator: FSM encoding, default widths
// and the saturating add used by the accumulator datapath.
package mac_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Adds at w+1 bits; bit 32 of the result flags a clamp to 2^w-1.
  // Operands must already fit in w bits, so the carry lands exactly on bit w.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (s[w]) return {1'b1, lim[31:0]};
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/mac_accumulator_sat_adder.sv
// Combinational saturating adder: acc + prod clamped to all ones on carry out.
module sat_adder
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  logic [32:0] r;
  logic        unused_hi;

  always_comb r = sat_add(32'(acc), 32'(prod), ACC_W);

  assign sum       = r[ACC_W-1:0];
  assign sat       = r[32];
  assign unused_hi = ^r[31:ACC_W];

endmodule

// File: rtl/mac_accumulator.sv
// Saturating dot-product accumulator fed by the multiplier's product stream.
// Handshake: a product is taken on a rising edge where prod_valid && prod_ready.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_TERMS = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [CNT_W-1:0]  count
);

  state_t           state;
  logic [ACC_W-1:0] sum;
  logic             sat;
  logic             accept;

  sat_adder #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_sat_adder (
    .acc  (acc),
    .prod (prod),
    .sum  (sum),
    .sat  (sat)
  );

  // Ready depends on state alone so upstream never sees a comb path from valid.
  assign prod_ready = (state == S_ACCUM);
  assign busy       = (state == S_ACCUM);
  assign accept     = prod_valid && prod_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            acc   <= sum;
            if (sat) ovf <= 1'b1;
            if (count == CNT_W'(N_TERMS - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // A start here chains straight into the next transaction.
          if (start) begin
            state <= S_ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 unsigned multiplier. It consumes its 8-bit products.
- Sums N_TERMS products per transaction into a saturating accumulator. This forms a dot product of operand pairs streamed through the multiplier.
- Valid/ready handshake on the product input. One-cycle done pulse with the result held until the next start.

Parameters:
- PROD_W, 8, width of incoming product (multiplier output width)
- ACC_W, 12, accumulator/result width; must be >= PROD_W
- N_TERMS, 4, products summed per transaction; range 1..255
- CNT_W, 8, width of the term counter; must hold N_TERMS

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin new transaction; sampled only in IDLE or DONE
- prod_valid  input  1  prod carries a valid product this cycle
- prod  input  PROD_W  unsigned product from multiplier
- prod_ready  output  1  block accepts prod this cycle
- acc  output  ACC_W  running/final sum, unsigned
- busy  output  1  transaction in progress (ACCUM state)
- done  output  1  one-cycle pulse when N_TERMS products have been accumulated
- ovf  output  1  sticky: saturation occurred in the current or last transaction
- count  output  CNT_W  products accepted in the current transaction

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; acc=0, count=0, ovf=0, done=0, busy=0, prod_ready=0.
- States: IDLE, ACCUM, DONE. Encoding is a localparam in the package.
- IDLE:
  - prod_ready=0.
  - start=1 -> next cycle ACCUM with acc=0, count=0, ovf=0.
  - Otherwise hold all values.
- ACCUM:
  - busy=1, prod_ready=1 (combinational from state only; no dependence on prod_valid).
  - Accept when prod_valid & prod_ready. On accept: count<=count+1 and acc<=sat(acc+prod).
  - Sum is computed at ACC_W+1 bits. If the carry bit is set, acc<=all ones (2^ACC_W-1) and ovf<=1.
  - Once saturated, acc stays at all ones for the rest of the transaction.
  - prod_valid=0: hold all values; no timeout.
  - Accept with count==N_TERMS-1 -> next state DONE. done=1 is registered and asserted in the DONE cycle.
  - start in ACCUM is ignored.
- DONE:
  - done=1 for exactly this cycle; prod_ready=0; acc, count (=N_TERMS) and ovf hold.
  - start=1 in DONE -> ACCUM directly with acc/count/ovf cleared, giving back-to-back transactions with no IDLE gap.
  - Otherwise -> IDLE, with acc/count/ovf still holding the last result.
- Latency: the result is valid and done asserts 1 cycle after the N_TERMS-th accept. Minimum transaction is N_TERMS+1 cycles from the start-sample edge to done.
- N_TERMS=1: first accept -> DONE.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. The partial sum is discarded.
- prod_valid while not ready is ignored; the product is not queued.

Decomposition:
- Shared package mac_pkg holds:
  - FSM state localparams (S_IDLE, S_ACCUM, S_DONE)
  - default widths PROD_W/ACC_W
  - a sat_add function (ACC_W+1 bit add with clamp)
- One natural sub-module: sat_adder (combinational, inputs acc and prod, outputs sum and sat flag). The FSM/counter/registers stay in the top.

Test Plan:
- Reset and basic sum: assert rst_n=0, then release. Expect all outputs 0. Pulse start, then feed products 15,30,45,60 (valid every cycle). Expect acc=150, count=4, done high exactly 1 cycle after the 4th accept, ovf=0.
- Stalls: same products with prod_valid dropped for 3 cycles between each. Expect acc=150 and done only after the 4th accept; acc and count hold during gaps.
- Saturation: override N_TERMS=20, feed 225 twenty times (sum 4500). Expect acc=4095 once the running sum exceeds 4095 (at the 19th accept), acc still 4095 at done, ovf=1. Then issue a new start: expect ovf=0 and acc=0.
- Back-to-back: start held high in the DONE cycle; second set of products 1,2,3,4. Expect ACCUM entered with no IDLE cycle, acc=10, second done 1 cycle after the 4th accept.
- Mid-transaction reset: after 2 accepts (acc=45), pull rst_n low asynchronously between clock edges. Expect acc=0, busy=0, prod_ready=0 immediately; after release the block stays IDLE until start.
- Ignored inputs: start pulsed in ACCUM mid-transaction, and prod_valid=1 with prod=200 in IDLE. Expect no restart, no change to acc or count, and prod_ready=0 in IDLE.
